uart_frame_engine: RTL and testbench

//  Byte-stream frame processor between a UART receiver and a UART transmitter.
//  - Buffers incoming bytes in a parametrised FIFO.
//  - Applies a run-time selectable per-byte operation.
//  - Returns each frame of bleng processed bytes, followed by one appended checksum byte.

---
 rtl/uart_frame_engine.sv | 167 ++++++++++++++++
 tb/tb_uart_frame_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_engine.sv
// uart_frame_engine
//   Frame processor between a UART receiver and a UART transmitter. It buffers
//   received bytes in a FIFO, applies a per-frame selectable byte operation,
//   sends each processed byte, and then appends a modular-sum checksum byte
//   to close the frame.
//
//   state | meaning
//   IDLE  | no frame; waiting for a buffered byte and a non-zero bleng
//   POP   | read FIFO head, register processed byte into o_data
//   SEND  | wait for TX ready, strobe o_send, accumulate checksum
//   WAIT  | wait for TX to take the byte (i_rdy low); next byte or checksum
//   CSUM  | o_data holds checksum; strobe o_send when TX ready
//   CWAIT | wait for TX to take checksum, pulse o_frame_done
//
// Ports
//   i_clk, reset             clock, async active-low reset
//   bleng, i_mode, i_thresh  frame config, latched at frame start
//   i_data, i_valid          received byte and its 1-cycle strobe
//   i_rdy                    TX idle / able to accept a byte
//   o_data, o_send           byte to transmit and its 1-cycle strobe
//   o_busy                   frame in progress
//   o_overflow               sticky: byte dropped on full FIFO
//   o_frame_done             1-cycle pulse after checksum handoff
module uart_frame_engine #(
  parameter int D_BITS     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 32
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  bleng,
  input  logic [1:0]        i_mode,
  input  logic [D_BITS-1:0] i_thresh,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_rdy,
  output logic [D_BITS-1:0] o_data,
  output logic              o_send,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, POP, SEND, WAIT, CSUM, CWAIT} state_t;
  state_t state, state_nxt;

  logic [D_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill;
  logic              full, empty, push, pop;

  logic [LEN_W-1:0]  bleng_q, count;
  logic [1:0]        mode_q;
  logic [D_BITS-1:0] thresh_q, csum, prev, head, result;
  logic [D_BITS:0]   sum_w;
  logic              start;

  assign full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty = (fill == '0);
  assign pop   = (state == POP);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push  = i_valid && (!full || pop);
  assign head  = mem[rd_ptr];
  assign start = (state == IDLE) && !empty && (bleng != '0);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
      if (i_valid && full && !pop) o_overflow <= 1'b1;
    end
  end

  // Average uses one extra bit so the carry of prev + d is not lost.
  assign sum_w = {1'b0, prev} + {1'b0, head};

  always_comb begin
    result = head;
    case (mode_q)
      2'b00: result = head;
      2'b01: result = ~head;
      2'b10: result = (head >= thresh_q) ? '1 : '0;
      2'b11: result = D_BITS'(sum_w >> 1);
      default: result = head;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      bleng_q  <= '0;
      mode_q   <= 2'b00;
      thresh_q <= '0;
      count    <= '0;
      csum     <= '0;
      prev     <= '0;
      o_data   <= '0;
    end else begin
      if (start) begin
        bleng_q  <= bleng;
        mode_q   <= i_mode;
        thresh_q <= i_thresh;
        count    <= '0;
        csum     <= '0;
        prev     <= '0;
      end
      if (state == POP) begin
        o_data <= result;
        if (mode_q == 2'b11) prev <= head;
      end
      if (state == SEND && i_rdy) begin
        csum  <= csum + o_data;
        count <= count + LEN_W'(1);
      end
      if (state == WAIT && !i_rdy && count == bleng_q) o_data <= csum;
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_send       = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = POP;
      POP:   state_nxt = SEND;
      SEND:  if (i_rdy) begin
               o_send    = 1'b1;
               state_nxt = WAIT;
             end
      WAIT:  if (!i_rdy) begin
               if (count == bleng_q) state_nxt = CSUM;
               else if (!empty)      state_nxt = POP;
             end
      CSUM:  if (i_rdy) begin
               o_send    = 1'b1;
               state_nxt = CWAIT;
             end
      CWAIT: if (!i_rdy) begin
               o_frame_done = 1'b1;
               state_nxt    = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_engine.sv
// Testbench for uart_frame_engine: directed frames with a scoreboard queue of
// expected transmitted bytes, drained by a TX-side monitor.
module tb_uart_frame_engine;

  localparam int DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        reset;
  logic [31:0] bleng;
  logic [1:0]  i_mode;
  logic [7:0]  i_thresh;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_rdy;
  logic [7:0]  o_data;
  logic        o_send;
  logic        o_busy;
  logic        o_overflow;
  logic        o_frame_done;

  uart_frame_engine #(.D_BITS(8), .FIFO_DEPTH(DEPTH), .LEN_W(32)) dut (
    .i_clk(i_clk), .reset(reset), .bleng(bleng), .i_mode(i_mode),
    .i_thresh(i_thresh), .i_data(i_data), .i_valid(i_valid), .i_rdy(i_rdy),
    .o_data(o_data), .o_send(o_send), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int send_cnt = 0;
  int frame_cnt = 0;
  int exp_frames = 0;
  logic tx_hold = 1'b0;
  logic [7:0] exp_q[$];

  // TX model and monitor: raise i_rdy unless held, take each strobed byte,
  // then drop i_rdy for two cycles to mimic the UART shifting it out.
  initial begin
    logic [7:0] e;
    i_rdy = 1'b0;
    forever begin
      @(negedge i_clk);
      i_rdy = !tx_hold;
      #1;
      if (o_send) begin
        send_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_send: got 0x%02h, none expected", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", o_data, e);
          end
        end
        @(posedge i_clk); #1 i_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
      end
    end
  end

  always @(negedge i_clk) if (o_frame_done) frame_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge i_clk);
    i_data  = d;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [7:0] th,
                           input logic [7:0] din[$], input logic [7:0] dexp[$]);
    logic [7:0] cs = 8'h00;
    i_mode = mode; i_thresh = th; bleng = 32'(din.size());
    foreach (dexp[k]) begin exp_q.push_back(dexp[k]); cs = cs + dexp[k]; end
    exp_q.push_back(cs);
    exp_frames++;
    foreach (din[k]) push_byte(din[k]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || frame_cnt != exp_frames || o_busy) && n < 3000) begin
      @(negedge i_clk); n++;
    end
    chk({name, "_timeout"}, 32'(n >= 3000), 32'd0);
    chk({name, "_frames"}, 32'(frame_cnt), 32'(exp_frames));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int s0;
    logic [7:0] din[$], dexp[$];
    reset = 1'b0; bleng = '0; i_mode = 2'b00; i_thresh = '0;
    i_data = '0; i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_data",  32'(o_data), 32'h0);
    chk("rst_send",  32'(o_send), 32'h0);
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_ovf",   32'(o_overflow), 32'h0);
    chk("rst_done",  32'(o_frame_done), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Pass-through
    din = '{8'h10, 8'h20, 8'h30}; dexp = '{8'h10, 8'h20, 8'h30};
    run_frame(2'b00, 8'h00, din, dexp);
    drain("pass");

    // 2-tap average
    din = '{8'h10, 8'h30, 8'hFF}; dexp = '{8'h08, 8'h20, 8'h97};
    run_frame(2'b11, 8'h00, din, dexp);
    drain("avg");

    // Threshold boundary
    din = '{8'h7F, 8'h80}; dexp = '{8'h00, 8'hFF};
    run_frame(2'b10, 8'h80, din, dexp);
    drain("thresh");

    // Invert
    din = '{8'h00, 8'hA5}; dexp = '{8'hFF, 8'h5A};
    run_frame(2'b01, 8'h00, din, dexp);
    drain("invert");

    // Overflow: hold engine idle, fill FIFO, then two extra bytes.
    tx_hold = 1'b1; bleng = 32'd0; i_mode = 2'b00;
    for (int i = 1; i <= DEPTH; i++) push_byte(8'(i));
    chk("ovf_at_full", 32'(o_overflow), 32'h0);
    push_byte(8'h11); push_byte(8'h12);
    chk("ovf_set", 32'(o_overflow), 32'h1);
    chk("ovf_idle", 32'(o_busy), 32'h0);
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h88);
    exp_frames++;
    bleng = 32'(DEPTH);
    tx_hold = 1'b0;
    drain("ovf");
    chk("ovf_sticky", 32'(o_overflow), 32'h1);

    // Reset mid-frame after the 2nd byte of a 4-byte average frame.
    i_mode = 2'b11; bleng = 32'd4;
    exp_q.push_back(8'h20); exp_q.push_back(8'h40);
    push_byte(8'h40); push_byte(8'h40);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(negedge i_clk); n++; end
      chk("abort_pre_timeout", 32'(n >= 500), 32'd0);
    end
    repeat (6) @(negedge i_clk);
    chk("abort_busy_before", 32'(o_busy), 32'h1);
    s0 = send_cnt;
    reset = 1'b0;
    #1;
    chk("abort_data",  32'(o_data), 32'h0);
    chk("abort_busy",  32'(o_busy), 32'h0);
    chk("abort_ovf",   32'(o_overflow), 32'h0);
    chk("abort_send",  32'(o_send), 32'h0);
    repeat (3) @(negedge i_clk);
    reset = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("abort_no_send", 32'(send_cnt - s0), 32'd0);
    chk("abort_frames", 32'(frame_cnt), 32'(exp_frames));

    // New frame after reset: prev and csum must restart from 0.
    din = '{8'h20, 8'h60}; dexp = '{8'h10, 8'h40};
    run_frame(2'b11, 8'h00, din, dexp);
    drain("post_reset");

    // bleng=0 holds bytes in the FIFO until a non-zero length appears.
    i_mode = 2'b00; bleng = 32'd0;
    s0 = send_cnt;
    push_byte(8'h11); push_byte(8'h22);
    repeat (10) @(negedge i_clk);
    chk("zero_len_send", 32'(send_cnt - s0), 32'd0);
    chk("zero_len_busy", 32'(o_busy), 32'h0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_frames++;
    bleng = 32'd2;
    drain("zero_len");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
